// File: rtl/uart_pkg.sv
// Shared definitions for the uart_fifo_ctrl peripheral: register offsets,
// STATUS bit positions, TX/RX state encodings, reset baud divisor and the
// parity helper.
// Optional feature macro: UART_PARITY_EN. It adds the PARITY states to both
// state enums.
package uart_pkg;

    localparam int unsigned BAUD_DIV_DEFAULT = 868;

    localparam logic [4:0] REG_TXDATA = 5'h00;
    localparam logic [4:0] REG_STATUS = 5'h04;
    localparam logic [4:0] REG_CTRL   = 5'h08;
    localparam logic [4:0] REG_RXDATA = 5'h0C;
    localparam logic [4:0] REG_LEVEL  = 5'h10;

    localparam int unsigned ST_TX_BUSY    = 0;
    localparam int unsigned ST_TX_FULL    = 1;
    localparam int unsigned ST_TX_EMPTY   = 2;
    localparam int unsigned ST_RX_AVAIL   = 3;
    localparam int unsigned ST_RX_FULL    = 4;
    localparam int unsigned ST_RX_OVR     = 5;
    localparam int unsigned ST_FRAME_ERR  = 6;
    localparam int unsigned ST_PARITY_ERR = 7;
    localparam int unsigned ST_TX_OVF     = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_e;

    // Parity bit for a byte: even parity when odd=0, odd parity when odd=1.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational head output.
// Ports: clk, rst_n (async active-low, flushes), push/wdata, pop,
// rdata (head), full, empty, count (entries held, $clog2(DEPTH)+1 bits).
// A push while full or a pop while empty is ignored; full/empty are the
// values before the edge, so a push to a full FIFO is dropped even with a
// simultaneous pop.
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART (8N1) bus slave with TX/RX FIFOs and sticky error flags.
// Ports: clk, rst_n (async active-low), bus request req_valid/req_write/
// req_addr/req_wdata/req_wstrb (wstrb ignored), combinational rdata for the
// current req_addr[4:0], serial uart_rx (asynchronous) and uart_tx (registered).
// Registers: 0x00 TXDATA, 0x04 STATUS (W1C [8:5]), 0x08 CTRL, 0x0C RXDATA
// (read pops), 0x10 LEVEL.
// Optional feature macro: UART_PARITY_EN (CTRL[16]=parity_en, CTRL[17]=parity_odd).
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TX_DEPTH         = 16,
    parameter int unsigned RX_DEPTH         = 16,
    parameter int unsigned BAUD_DIV_DEFAULT = uart_pkg::BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int unsigned TXC_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RXC_W = $clog2(RX_DEPTH) + 1;
    localparam logic [15:0] BAUD_RST = 16'(BAUD_DIV_DEFAULT);

    logic [4:0]       offset_s;
    logic             wr_s, rd_s;
    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [7:0]       tx_head_s;
    logic [TXC_W-1:0] tx_count_s;
    logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]       rx_head_s;
    logic [RXC_W-1:0] rx_count_s;
    logic [3:0]       clr_s;
    logic [8:0]       status_s;
    logic [31:0]      level_s;
    logic [31:0]      ctrl_s;
    logic             frame_err_set_s, parity_err_set_s;
    logic             unused_s;

    logic [15:0] baud_div_r;
    logic [7:0]  tx_last_r;
    logic        rx_ovr_r, frame_err_r, parity_err_r, tx_ovf_r;
`ifdef UART_PARITY_EN
    logic        parity_en_r, parity_odd_r;
    logic        rx_par_r, rx_par_n;
`endif

    tx_state_e   tx_state_r, tx_state_n;
    logic [15:0] tx_cnt_r, tx_cnt_n, tx_baud_r, tx_baud_n;
    logic [2:0]  tx_bit_r, tx_bit_n;
    logic [7:0]  tx_data_r, tx_data_n;
    logic        tx_line_r, tx_line_n;

    rx_state_e   rx_state_r, rx_state_n;
    logic [15:0] rx_cnt_r, rx_cnt_n, rx_baud_r, rx_baud_n, rx_half_s;
    logic [2:0]  rx_bit_r, rx_bit_n;
    logic [7:0]  rx_shift_r, rx_shift_n;
    logic        rx_sync1_r, rx_sync2_r, rx_prev_r;

    assign unused_s  = ^{req_wstrb, req_addr[31:5], req_wdata[31:16]};
    assign offset_s  = req_addr[4:0];
    assign wr_s      = req_valid & req_write;
    assign rd_s      = req_valid & ~req_write;
    assign tx_push_s = wr_s & (offset_s == REG_TXDATA);
    assign rx_pop_s  = rd_s & (offset_s == REG_RXDATA);
    assign clr_s     = (wr_s && (offset_s == REG_STATUS)) ? req_wdata[8:5] : 4'b0000;
    assign rx_half_s = {1'b0, baud_div_r[15:1]};
    assign uart_tx   = tx_line_r;

    uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push_s), .pop(tx_pop_s),
        .wdata(req_wdata[7:0]), .rdata(tx_head_s), .full(tx_full_s),
        .empty(tx_empty_s), .count(tx_count_s)
    );

    uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_s), .pop(rx_pop_s),
        .wdata(rx_shift_r), .rdata(rx_head_s), .full(rx_full_s),
        .empty(rx_empty_s), .count(rx_count_s)
    );

    // Register-file state: last TX byte, baud divisor, sticky flags (set wins over W1C).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_last_r    <= 8'h00;
            baud_div_r   <= BAUD_RST;
            rx_ovr_r     <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            tx_ovf_r     <= 1'b0;
`ifdef UART_PARITY_EN
            parity_en_r  <= 1'b0;
            parity_odd_r <= 1'b0;
`endif
        end else begin
            if (tx_push_s && !tx_full_s) begin
                tx_last_r <= req_wdata[7:0];
            end
            if (wr_s && (offset_s == REG_CTRL)) begin
                baud_div_r <= (req_wdata[15:0] == 16'd0) ? 16'd1 : req_wdata[15:0];
`ifdef UART_PARITY_EN
                parity_en_r  <= req_wdata[16];
                parity_odd_r <= req_wdata[17];
`endif
            end
            rx_ovr_r     <= (rx_ovr_r & ~clr_s[0]) | (rx_push_s & rx_full_s);
            frame_err_r  <= (frame_err_r & ~clr_s[1]) | frame_err_set_s;
            parity_err_r <= (parity_err_r & ~clr_s[2]) | parity_err_set_s;
            tx_ovf_r     <= (tx_ovf_r & ~clr_s[3]) | (tx_push_s & tx_full_s);
        end
    end

    // TX next-state: a pop at IDLE or at the last STOP cycle starts a frame on the same edge.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_baud_n  = tx_baud_r;
        tx_bit_n   = tx_bit_r;
        tx_data_n  = tx_data_r;
        tx_line_n  = tx_line_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE, TX_STOP: begin
                if ((tx_state_r == TX_STOP) && (tx_cnt_r != 16'd0)) begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end else if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_data_n  = tx_head_s;
                    tx_baud_n  = baud_div_r;
                    tx_cnt_n   = baud_div_r - 16'd1;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end else begin
                    tx_line_n  = 1'b1;
                    tx_state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = 3'd0;
                    tx_cnt_n   = tx_baud_r - 16'd1;
                    tx_line_n  = tx_data_r[0];
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_n = tx_baud_r - 16'd1;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
`ifdef UART_PARITY_EN
                        if (parity_en_r) begin
                            tx_state_n = TX_PARITY;
                            tx_line_n  = parity_bit(tx_data_r, parity_odd_r);
                        end else begin
                            tx_state_n = TX_STOP;
                        end
`endif
                    end else begin
                        tx_bit_n  = tx_bit_r + 3'd1;
                        tx_line_n = tx_data_r[tx_bit_r + 3'd1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = tx_baud_r - 16'd1;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
`endif
            default: begin
                tx_state_n = TX_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    // RX next-state: sample mid-bit (half a bit after the start edge, then every bit).
    always_comb begin
        rx_state_n       = rx_state_r;
        rx_cnt_n         = rx_cnt_r;
        rx_baud_n        = rx_baud_r;
        rx_bit_n         = rx_bit_r;
        rx_shift_n       = rx_shift_r;
        rx_push_s        = 1'b0;
        frame_err_set_s  = 1'b0;
        parity_err_set_s = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_n         = rx_par_r;
`endif
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync2_r) begin
                    rx_state_n = RX_START;
                    rx_baud_n  = baud_div_r;
                    rx_cnt_n   = (rx_half_s == 16'd0) ? 16'd0 : rx_half_s - 16'd1;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r != 16'd0) begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end else if (rx_sync2_r) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_DATA;
                    rx_bit_n   = 3'd0;
                    rx_cnt_n   = rx_baud_r - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_shift_n = {rx_sync2_r, rx_shift_r[7:1]};
                    rx_cnt_n   = rx_baud_r - 16'd1;
                    rx_bit_n   = rx_bit_r + 3'd1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = RX_STOP;
`ifdef UART_PARITY_EN
                        if (parity_en_r) begin
                            rx_state_n = RX_PARITY;
                        end else begin
                            rx_state_n = RX_STOP;
                        end
`endif
                    end else begin
                        rx_state_n = RX_DATA;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_par_n   = rx_sync2_r;
                    rx_state_n = RX_STOP;
                    rx_cnt_n   = rx_baud_r - 16'd1;
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_state_n      = RX_IDLE;
                    frame_err_set_s = ~rx_sync2_r;
`ifdef UART_PARITY_EN
                    parity_err_set_s = parity_en_r &
                                       (rx_par_r != parity_bit(rx_shift_r, parity_odd_r));
`endif
                    rx_push_s = rx_sync2_r & ~parity_err_set_s;
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // FSM state/datapath registers and the 2-flop uart_rx synchroniser (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_baud_r  <= 16'd1;
            tx_bit_r   <= 3'd0;
            tx_data_r  <= 8'h00;
            tx_line_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_baud_r  <= 16'd1;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
`ifdef UART_PARITY_EN
            rx_par_r   <= 1'b0;
`endif
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_baud_r  <= tx_baud_n;
            tx_bit_r   <= tx_bit_n;
            tx_data_r  <= tx_data_n;
            tx_line_r  <= tx_line_n;
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_baud_r  <= rx_baud_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
            rx_sync1_r <= uart_rx;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
`ifdef UART_PARITY_EN
            rx_par_r   <= rx_par_n;
`endif
        end
    end

    // Read-side views of STATUS, CTRL and LEVEL.
    always_comb begin
        status_s                = 9'd0;
        status_s[ST_TX_BUSY]    = (tx_state_r != TX_IDLE) | ~tx_empty_s;
        status_s[ST_TX_FULL]    = tx_full_s;
        status_s[ST_TX_EMPTY]   = tx_empty_s;
        status_s[ST_RX_AVAIL]   = ~rx_empty_s;
        status_s[ST_RX_FULL]    = rx_full_s;
        status_s[ST_RX_OVR]     = rx_ovr_r;
        status_s[ST_FRAME_ERR]  = frame_err_r;
        status_s[ST_PARITY_ERR] = parity_err_r;
        status_s[ST_TX_OVF]     = tx_ovf_r;
`ifdef UART_PARITY_EN
        ctrl_s = {14'd0, parity_odd_r, parity_en_r, baud_div_r};
`else
        ctrl_s = {16'd0, baud_div_r};
`endif
        level_s                   = 32'd0;
        level_s[TXC_W-1:0]        = tx_count_s;
        level_s[16 +: RXC_W]      = rx_count_s;
    end

    // Combinational read mux; unmapped offsets and an empty RXDATA read 0.
    always_comb begin
        rdata = 32'd0;
        case (offset_s)
            REG_TXDATA: rdata = {24'd0, tx_last_r};
            REG_STATUS: rdata = {23'd0, status_s};
            REG_CTRL:   rdata = ctrl_s;
            REG_RXDATA: rdata = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
            REG_LEVEL:  rdata = level_s;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl with TX/RX byte scoreboards.
module tb_uart_fifo_ctrl;

    localparam logic [4:0] A_TXDATA = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_CTRL   = 5'h08;
    localparam logic [4:0] A_RXDATA = 5'h0C;
    localparam logic [4:0] A_LEVEL  = 5'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h4000_0200;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'hF;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .BAUD_DIV_DEFAULT(868)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a falling clock edge.
    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        req_valid = 1'b1; req_write = 1'b1;
        req_addr  = 32'h4000_0200 | {27'd0, off};
        req_wdata = data;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] data);
        req_valid = 1'b1; req_write = 1'b0;
        req_addr  = 32'h4000_0200 | {27'd0, off};
        #1 data = rdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, d);
        check_val(tag, d, exp);
    endtask

    // Wait for the start bit, then check every cycle of nframes frames against the scoreboard.
    task automatic tx_capture(input int baud, input int nframes, output int lat);
        logic [7:0] exp_b, got_b;
        logic [9:0] fr;
        int         errs;
        logic       seen;
        lat = 0; seen = 1'b0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            lat++;
            if (uart_tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("tx_start_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        for (int f = 0; f < nframes; f++) begin
            check_val("tx_q_nonempty", {31'd0, (tx_q.size() != 0)}, 32'd1);
            if (tx_q.size() == 0) return;
            exp_b = tx_q.pop_front();
            fr    = {1'b1, exp_b, 1'b0};
            errs  = 0; got_b = 8'h00;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < baud; c++) begin
                    if (!(f == 0 && b == 0 && c == 0)) @(negedge clk);
                    if (uart_tx !== fr[b]) errs++;
                    if (b >= 1 && b <= 8 && c == baud / 2) got_b[b-1] = uart_tx;
                end
            end
            check_val("tx_byte", {24'd0, got_b}, {24'd0, exp_b});
            check_val("tx_wave_errs", errs, 32'd0);
        end
    endtask

    task automatic rx_send(input logic [7:0] data, input logic stop_bit, input int baud);
        logic [9:0] fr;
        fr = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rx = fr[b];
            repeat (baud) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (baud) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] d;

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        read_check("rst_txdata", A_TXDATA, 32'h0);
        read_check("rst_status", A_STATUS, 32'h4);
        read_check("rst_ctrl",   A_CTRL,   32'd868);
        read_check("rst_rxdata", A_RXDATA, 32'h0);
        read_check("rst_level",  A_LEVEL,  32'h0);
        read_check("rst_unmapped", 5'h14,  32'h0);

        // Baud clamp, then a single 0x55 frame at baud 4
        bus_write(A_CTRL, 32'd0);
        read_check("ctrl_clamp", A_CTRL, 32'd1);
        bus_write(A_CTRL, 32'd4);
        tx_q.push_back(8'h55);
        bus_write(A_TXDATA, 32'h55);
        check_val("tx_idle_at_e0", {31'd0, uart_tx}, 32'd1);
        tx_capture(4, 1, lat);
        check_val("tx_start_lat", lat, 32'd1);
        read_check("tx_busy_last_stop", A_STATUS, 32'h5);
        read_check("tx_busy_clear", A_STATUS, 32'h4);
        read_check("txdata_last", A_TXDATA, 32'h55);

        // Three back-to-back bytes: no gap between frames
        tx_q.push_back(8'hA1); tx_q.push_back(8'h0F); tx_q.push_back(8'hC3);
        fork
            tx_capture(4, 3, lat);
            begin
                bus_write(A_TXDATA, 32'hA1);
                bus_write(A_TXDATA, 32'h0F);
                bus_write(A_TXDATA, 32'hC3);
                read_check("level_after_3", A_LEVEL, 32'd2);
            end
        join
        read_check("level_drained", A_LEVEL, 32'd0);

        // Overflow: 18 writes while busy, 17 accepted
        for (int i = 0; i < 17; i++) tx_q.push_back(8'(i * 13 + 7));
        fork
            tx_capture(4, 17, lat);
            begin
                for (int i = 0; i < 18; i++) bus_write(A_TXDATA, 32'(8'(i * 13 + 7)));
                read_check("level_cap", A_LEVEL, 32'd16);
                read_check("status_ovf", A_STATUS, 32'h103);
                bus_write(A_STATUS, 32'h100);
                read_check("status_ovf_w1c", A_STATUS, 32'h003);
            end
        join
        repeat (2) @(negedge clk);
        read_check("status_tx_done", A_STATUS, 32'h4);

        // RX: two good frames at baud 8
        bus_write(A_CTRL, 32'd8);
        rx_q.push_back(8'hA3); rx_q.push_back(8'h3C);
        rx_send(8'hA3, 1'b1, 8);
        rx_send(8'h3C, 1'b1, 8);
        read_check("rx_level2", A_LEVEL, 32'h0002_0000);
        for (int i = 0; i < 2; i++) begin
            bus_read(A_RXDATA, d);
            check_val("rx_byte", d, {24'd0, rx_q.pop_front()});
        end
        read_check("rx_empty_read", A_RXDATA, 32'h0);
        read_check("rx_level0", A_LEVEL, 32'h0);

        // Short glitch: no byte, no flag
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        read_check("glitch_status", A_STATUS, 32'h4);
        read_check("glitch_level", A_LEVEL, 32'h0);

        // Stop bit 0: frame_err, nothing pushed
        rx_send(8'h5A, 1'b0, 8);
        read_check("frame_err_status", A_STATUS, 32'h44);
        read_check("frame_err_level", A_LEVEL, 32'h0);
        bus_write(A_STATUS, 32'h40);
        read_check("frame_err_w1c", A_STATUS, 32'h4);

        // RX overrun: fill 16, send one more
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'(i * 29 + 3));
            rx_send(8'(i * 29 + 3), 1'b1, 8);
        end
        rx_send(8'hEE, 1'b1, 8);
        read_check("rx_ovr_status", A_STATUS, 32'h3C);
        read_check("rx_ovr_level", A_LEVEL, 32'h0010_0000);
        for (int i = 0; i < 16; i++) begin
            bus_read(A_RXDATA, d);
            check_val("rx_drain", d, {24'd0, rx_q.pop_front()});
        end
        read_check("rx_drained_read", A_RXDATA, 32'h0);
        read_check("rx_ovr_sticky", A_STATUS, 32'h24);
        bus_write(A_STATUS, 32'h20);
        read_check("rx_ovr_w1c", A_STATUS, 32'h4);

        // Reset in mid-frame
        bus_write(A_TXDATA, 32'hC3);
        bus_write(A_TXDATA, 32'h81);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1 check_val("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_check("midrst_status", A_STATUS, 32'h4);
        read_check("midrst_level", A_LEVEL, 32'h0);
        read_check("midrst_ctrl", A_CTRL, 32'd868);
        repeat (20) @(negedge clk);
        check_val("midrst_tx_idle", {31'd0, uart_tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Second-generation UART peripheral on the bus_simple slave port at base 0x4000_0200 (8N1). Adds a parametrised TX FIFO, a full RX path with a parametrised RX FIFO, and sticky error flags.
Register map is a superset of the V1 UART (offsets 0x00–0x0C keep their meaning; 0x10 is added). Fully synchronous to one clock.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of two, ≥2
RX_DEPTH, 16, RX FIFO entries; power of two, ≥2
BAUD_DIV_DEFAULT, 868, reset value of baud_div (100 MHz / 115200)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  bus request strobe, one cycle per access
req_write  in  1  1=write, 0=read
req_addr  in  32  byte address; [4:0] is the register offset, the rest is ignored
req_wdata  in  32  write data
req_wstrb  in  4  ignored; full-word access
rdata  out  32  combinational read data for the current req_addr
uart_rx  in  1  asynchronous serial input
uart_tx  out  1  serial output, registered, idle high

Behaviour:
- Registers:
  - 0x00 TXDATA: a write pushes [7:0] into the TX FIFO. If the FIFO is full, the write is dropped and tx_ovf is set. A read returns the last accepted byte.
  - 0x04 STATUS: [0] tx_busy (FSM not idle OR TX FIFO non-empty), [1] tx_full, [2] tx_empty, [3] rx_avail, [4] rx_full, [5] rx_ovr, [6] frame_err, [7] parity_err, [8] tx_ovf. Writing 1 to bits [8:5] clears them (W1C). Writing 1 to a bit and setting it in the same cycle leaves the bit set.
  - 0x08 CTRL: [15:0] baud_div; writing 0 clamps to 1.
  - 0x0C RXDATA: a read returns the FIFO head in [7:0] and pops it on the same edge. When the FIFO is empty, a read returns 0 and does not pop.
  - 0x10 LEVEL: [7:0] tx_count, [23:16] rx_count.
  - Any other offset reads 0; writes to it are ignored.
- Reset values: uart_tx=1, both FIFOs empty, all flags 0, baud_div=BAUD_DIV_DEFAULT, TX and RX FSMs in IDLE. rdata is combinational, so after reset it reads register reset values.
- FIFO full and empty are evaluated before the clock edge. A push to a full FIFO is dropped even if a pop happens in the same cycle. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Baud rate: each FSM latches baud_div at frame start. Every bit lasts exactly baud_div cycles. A CTRL write mid-frame affects only the next frame.
- TX FSM (IDLE → START → DATA → [PARITY] → STOP):
  - IDLE with FIFO non-empty: pop the FIFO and go to START. uart_tx goes low on that same edge. A TXDATA write at edge E0 into an empty FIFO with the FSM idle gives the start bit at E1.
  - DATA: 8 bits, LSB first.
  - Last STOP cycle: if the FIFO is non-empty, pop and go directly to START, so there is no idle gap. A full frame is 10·baud_div cycles (11 with parity).
- RX:
  - Input: 2-flop synchroniser on uart_rx, both flops reset to 1.
  - IDLE: wait for a synchronised falling edge, then go to START.
  - START: wait floor(baud_div/2) cycles and sample. If the sample is 1 it is a false start: return to IDLE with no flags set.
  - DATA and STOP: sample every baud_div cycles thereafter.
  - Stop sample = 0: set frame_err and discard the byte.
  - Stop sample = 1: push the byte. If the RX FIFO is full, set rx_ovr and drop the byte.
  - After the stop sample, return to IDLE immediately. This gives half-bit slack for back-to-back frames.
- Reset asserted mid-frame aborts both FSMs, drives uart_tx high and flushes both FIFOs.
- Widths: FIFO counts are $clog2(DEPTH)+1 bits, zero-extended into LEVEL.

Optional Feature:
UART_PARITY_EN:
- Defined:
  - CTRL[16]=parity_en and CTRL[17]=parity_odd.
  - When parity_en=1, TX inserts a parity bit after D7. The bit is even parity by default, odd parity when parity_odd=1.
  - RX checks the parity bit. On a mismatch it sets parity_err and discards the byte. A stop-bit error in the same frame also sets frame_err.
- Undefined:
  - CTRL[17:16] read 0 and writes to them are ignored.
  - STATUS[7] reads 0 and the PARITY state is absent.

Decomposition:
- Package uart_pkg:
  - Register offsets (REG_TXDATA, REG_STATUS, REG_CTRL, REG_RXDATA, REG_LEVEL).
  - STATUS bit indices.
  - TX state enum and RX state enum.
  - BAUD_DIV_DEFAULT.
- Sub-module uart_sync_fifo:
  - Parameters DEPTH and WIDTH=8.
  - Signals: push, pop, wdata, rdata (head, combinational), full, empty, count.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then read all registers → STATUS=0x0000_0004, CTRL=868, LEVEL=0, uart_tx=1.
- Set baud_div=4 and write 0x55 → start bit at E1, then frame 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles; tx_busy clears after 40 cycles.
- With baud_div=4, write 3 bytes back-to-back → 120 contiguous cycles with no idle gap; LEVEL tx_count goes 3,2,1,0 at the pops.
- With TX_DEPTH=16 and the FSM busy, write 18 bytes → tx_count caps at 16, STATUS[8]=1; W1C 0x100 clears the bit.
- With baud_div=8, drive the RX line with 0xA3 and then 0x3C → RXDATA reads 0xA3 then 0x3C, then reads 0 when empty; a 3-cycle glitch low produces no byte and no flag; a frame with stop=0 sets frame_err and pushes nothing.
- With the RX FIFO filled to RX_DEPTH, send one more frame → rx_ovr=1, rx_count stays at RX_DEPTH, and the head byte is unchanged.
